// File: rtl/udp_rx_filter_if.sv
// Byte-stream interface of the UDP receive filter: RMII-side byte strobes in,
// payload beats and drop statistics out.
interface udp_rx_filter_if #(
    parameter int unsigned PORT_W = 2
);
    logic [7:0]        rx_byte;
    logic              rx_byte_valid;
    logic              rx_frame_end;
    logic [7:0]        payload;
    logic              payload_valid;
    logic              payload_last;
    logic [PORT_W-1:0] payload_port;
    logic              payload_abort;
    logic              drop_pulse;
    logic [15:0]       drop_count;

    modport master (
        output rx_byte, rx_byte_valid, rx_frame_end,
        input  payload, payload_valid, payload_last, payload_port, payload_abort,
        input  drop_pulse, drop_count
    );

    modport slave (
        input  rx_byte, rx_byte_valid, rx_frame_end,
        output payload, payload_valid, payload_last, payload_port, payload_abort,
        output drop_pulse, drop_count
    );
endinterface

// File: rtl/udp_rx_filter.sv
// Ethernet/IPv4/UDP receive filter: parses the header stream on the fly and forwards
// the payload of datagrams addressed to this station on a small range of UDP ports.
module udp_rx_filter #(
    parameter logic [47:0] FPGA_MAC         = 48'h00_1A_2B_3C_4D_5E,
    parameter logic [31:0] FPGA_IP          = 32'hC0_00_02_92,
    parameter logic [15:0] PORT_BASE        = 16'd5005,
    parameter int unsigned NUM_PORTS        = 4,
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter bit          CHECK_IP_CSUM    = 1'b1
) (
    input logic            clk,
    input logic            resetn,
    udp_rx_filter_if.slave bus
);
    localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {
        StIdle, StEthHdr, StIpHdr, StIpOpt, StUdpHdr, StPayload, StDrain
    } state_e;

    state_e state_q, state_d, byte_state;

    logic [15:0]       cnt_q;
    logic [7:0]        prev_q;
    logic              uc_ok_q, bc_ok_q, et_ok_q, ip_ok_q;
    logic [3:0]        ihl_q;
    logic [19:0]       acc_q;
    logic [15:0]       dport_q, len_q;
    logic [PORT_W-1:0] port_q;

    logic [7:0]  payload_q, payload_d;
    logic        valid_q, valid_d, last_q, last_d, abort_q, abort_d, drop_q, drop_d;
    logic [15:0] drop_count_q, drop_count_d;

    logic [19:0] csum_sum;
    logic        eth_pass, ip_fields_ok, csum_ok, port_ok, len_ok, opt_last, pay_last;
    logic        reject, beat, last, end_drop, end_abort;

    function automatic logic [7:0] mac_byte(input logic [2:0] idx);
        logic [47:0] sh;
        sh = FPGA_MAC >> (6'd40 - {idx, 3'b000});
        return sh[7:0];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [1:0] idx);
        logic [31:0] sh;
        sh = FPGA_IP >> (5'd24 - {idx, 3'b000});
        return sh[7:0];
    endfunction

    // One's-complement fold: end-around carry applied twice.
    function automatic logic [15:0] csum_fold(input logic [19:0] s);
        logic [16:0] f1, f2;
        f1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
        f2 = {1'b0, f1[15:0]} + {16'd0, f1[16]};
        return f2[15:0];
    endfunction

    assign csum_sum     = acc_q + {4'd0, prev_q, bus.rx_byte};
    assign csum_ok      = !CHECK_IP_CSUM || (csum_fold(csum_sum) == 16'hFFFF);
    assign eth_pass     = (uc_ok_q || (ACCEPT_BROADCAST && bc_ok_q)) && et_ok_q &&
                          (bus.rx_byte == 8'h00);
    assign ip_fields_ok = ip_ok_q && (bus.rx_byte == ip_byte(2'd3));
    assign opt_last     = (cnt_q == ({10'd0, ihl_q - 4'd5, 2'b00} - 16'd1));
    assign port_ok      = ({1'b0, dport_q} >= {1'b0, PORT_BASE}) &&
                          ({1'b0, dport_q} < ({1'b0, PORT_BASE} + 17'(NUM_PORTS)));
    assign len_ok       = (len_q >= 16'd8);
    assign pay_last     = (cnt_q == (len_q - 16'd9));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The byte is evaluated first; a coincident frame end then acts on the resulting state.
    always_comb begin
        byte_state = state_q;
        reject     = 1'b0;
        beat       = 1'b0;
        last       = 1'b0;
        if (bus.rx_byte_valid) begin
            case (state_q)
                StIdle: if (bus.rx_byte == 8'hD5) byte_state = StEthHdr;
                StEthHdr: begin
                    if (cnt_q == 16'd13) begin
                        byte_state = eth_pass ? StIpHdr : StDrain;
                        reject     = !eth_pass;
                    end
                end
                StIpHdr: begin
                    if (cnt_q == 16'd19) begin
                        if (!ip_fields_ok) begin
                            byte_state = StDrain;
                            reject     = 1'b1;
                        end else if (ihl_q != 4'd5) begin
                            byte_state = StIpOpt;
                        end else begin
                            byte_state = csum_ok ? StUdpHdr : StDrain;
                            reject     = !csum_ok;
                        end
                    end
                end
                StIpOpt: begin
                    if (opt_last) begin
                        byte_state = csum_ok ? StUdpHdr : StDrain;
                        reject     = !csum_ok;
                    end
                end
                StUdpHdr: begin
                    if (cnt_q == 16'd7) begin
                        if (port_ok && len_ok) begin
                            byte_state = (len_q == 16'd8) ? StDrain : StPayload;
                        end else begin
                            byte_state = StDrain;
                            reject     = 1'b1;
                        end
                    end
                end
                StPayload: begin
                    beat = 1'b1;
                    if (pay_last) begin
                        last       = 1'b1;
                        byte_state = StDrain;
                    end
                end
                default: ;
            endcase
        end

        state_d   = byte_state;
        end_drop  = 1'b0;
        end_abort = 1'b0;
        if (bus.rx_frame_end) begin
            state_d = StIdle;
            case (byte_state)
                StEthHdr, StIpHdr, StIpOpt, StUdpHdr: end_drop  = 1'b1;
                StPayload:                            end_abort = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        payload_d    = beat ? bus.rx_byte : 8'h00;
        valid_d      = beat;
        last_d       = last;
        abort_d      = end_abort;
        drop_d       = reject || end_drop;
        drop_count_d = drop_count_q;
        if (drop_d && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= '0;
            prev_q       <= '0;
            uc_ok_q      <= 1'b0;
            bc_ok_q      <= 1'b0;
            et_ok_q      <= 1'b0;
            ip_ok_q      <= 1'b0;
            ihl_q        <= '0;
            acc_q        <= '0;
            dport_q      <= '0;
            len_q        <= '0;
            port_q       <= '0;
            payload_q    <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            abort_q      <= 1'b0;
            drop_q       <= 1'b0;
            drop_count_q <= '0;
        end else begin
            payload_q    <= payload_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            abort_q      <= abort_d;
            drop_q       <= drop_d;
            drop_count_q <= drop_count_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (bus.rx_byte_valid) begin
                cnt_q <= cnt_q + 16'd1;
            end

            if (bus.rx_byte_valid) begin
                prev_q <= bus.rx_byte;
                case (state_q)
                    StEthHdr: begin
                        acc_q <= '0;
                        if (cnt_q < 16'd6) begin
                            uc_ok_q <= ((cnt_q == 16'd0) || uc_ok_q) &&
                                       (bus.rx_byte == mac_byte(cnt_q[2:0]));
                            bc_ok_q <= ((cnt_q == 16'd0) || bc_ok_q) && (bus.rx_byte == 8'hFF);
                        end
                        if (cnt_q == 16'd12) et_ok_q <= (bus.rx_byte == 8'h08);
                    end
                    StIpHdr: begin
                        if (cnt_q[0]) acc_q <= csum_sum;
                        case (cnt_q)
                            16'd0: begin
                                ihl_q   <= bus.rx_byte[3:0];
                                ip_ok_q <= (bus.rx_byte[7:4] == 4'd4) && (bus.rx_byte[3:0] >= 4'd5);
                            end
                            // MF flag and the top five fragment-offset bits.
                            16'd6:  ip_ok_q <= ip_ok_q && (bus.rx_byte[5:0] == 6'd0);
                            16'd7:  ip_ok_q <= ip_ok_q && (bus.rx_byte == 8'd0);
                            16'd9:  ip_ok_q <= ip_ok_q && (bus.rx_byte == 8'd17);
                            16'd16, 16'd17, 16'd18:
                                ip_ok_q <= ip_ok_q && (bus.rx_byte == ip_byte(cnt_q[1:0]));
                            default: ;
                        endcase
                    end
                    StIpOpt: if (cnt_q[0]) acc_q <= csum_sum;
                    StUdpHdr: begin
                        if (cnt_q == 16'd3) dport_q <= {prev_q, bus.rx_byte};
                        if (cnt_q == 16'd5) len_q <= {prev_q, bus.rx_byte};
                        if ((cnt_q == 16'd7) && port_ok && len_ok) begin
                            port_q <= PORT_W'(dport_q - PORT_BASE);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.payload       = payload_q;
    assign bus.payload_valid = valid_q;
    assign bus.payload_last  = last_q;
    assign bus.payload_port  = port_q;
    assign bus.payload_abort = abort_q;
    assign bus.drop_pulse    = drop_q;
    assign bus.drop_count    = drop_count_q;

endmodule

// File: tb/tb_udp_rx_filter.sv
// Scoreboard bench for udp_rx_filter: builds frames, queues the expected payload beats,
// aborts and drops, and matches them against DUT output events.
module tb_udp_rx_filter;
    localparam logic [47:0] MAC   = 48'h00_1A_2B_3C_4D_5E;
    localparam logic [1:0]  KBeat = 2'd0;
    localparam logic [1:0]  KAbort = 2'd1;
    localparam logic [1:0]  KDrop = 2'd2;

    typedef logic [12:0] ev_t;  // {kind, data, last, port}

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] rx_byte;
    logic       rx_valid, rx_end, nb_en;

    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_drops = 0;
    int   nb_beats = 0;
    int   nb_drops = 0;
    int   hdr_len = 0;
    ev_t  sb[$];
    logic [7:0] frm_q[$];
    logic [7:0] pay_q[$];

    udp_rx_filter_if #(.PORT_W(2)) bus ();
    udp_rx_filter_if #(.PORT_W(2)) nb ();

    assign bus.rx_byte       = rx_byte;
    assign bus.rx_byte_valid = rx_valid;
    assign bus.rx_frame_end  = rx_end;
    assign nb.rx_byte        = rx_byte;
    assign nb.rx_byte_valid  = rx_valid & nb_en;
    assign nb.rx_frame_end   = rx_end & nb_en;

    udp_rx_filter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    udp_rx_filter #(.ACCEPT_BROADCAST(1'b0)) dut_nb (
        .clk    (clk),
        .resetn (resetn),
        .bus    (nb)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag, input ev_t obs);
        ev_t e;
        if (sb.size() == 0) begin
            check({tag, "_unexpected"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            check(tag, obs, e);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (bus.payload_valid)
                pop_check("beat", {KBeat, bus.payload, bus.payload_last, bus.payload_port});
            if (bus.payload_abort) pop_check("abort", {KAbort, 8'h00, 1'b0, 2'd0});
            if (bus.drop_pulse)    pop_check("drop", {KDrop, 8'h00, 1'b0, 2'd0});
            if (nb.payload_valid) nb_beats++;
            if (nb.drop_pulse)    nb_drops++;
        end
    end

    task automatic exp_beats(input int n, input logic [1:0] port, input bit with_last);
        for (int i = 0; i < n; i++) sb.push_back({KBeat, pay_q[i], with_last && (i == n - 1), port});
    endtask

    task automatic exp_drop();
        sb.push_back({KDrop, 8'h00, 1'b0, 2'd0});
        exp_drops++;
    endtask

    task automatic build(input bit bcast, input int ihl, input logic [15:0] dport,
                         input logic [15:0] ulen, input bit mf, input bit bad);
        logic [7:0] h[$];
        int s;
        int tot;
        frm_q.delete();
        frm_q.push_back(8'h55);
        frm_q.push_back(8'h55);
        frm_q.push_back(8'hD5);
        for (int i = 0; i < 6; i++) frm_q.push_back(bcast ? 8'hFF : 8'(MAC >> (40 - 8 * i)));
        for (int i = 0; i < 6; i++) frm_q.push_back(8'(8'h02 + i));
        frm_q.push_back(8'h08);
        frm_q.push_back(8'h00);
        tot = ihl * 4 + int'(ulen);
        h = {8'h40 | 8'(ihl), 8'h00, 8'(tot >> 8), 8'(tot), 8'h12, 8'h34,
             mf ? 8'h20 : 8'h40, 8'h00, 8'h40, 8'h11, 8'h00, 8'h00,
             8'hC0, 8'h00, 8'h02, 8'h01, 8'hC0, 8'h00, 8'h02, 8'h92};
        for (int i = 20; i < ihl * 4; i++) h.push_back(8'h01);
        s = 0;
        for (int i = 0; i < h.size(); i += 2) s += int'({h[i], h[i + 1]});
        s = (s & 32'hFFFF) + (s >> 16);
        s = (s & 32'hFFFF) + (s >> 16);
        h[10] = 8'((~s) >> 8);
        h[11] = 8'(~s) ^ (bad ? 8'h01 : 8'h00);
        foreach (h[i]) frm_q.push_back(h[i]);
        frm_q.push_back(8'h1F);
        frm_q.push_back(8'h90);
        frm_q.push_back(dport[15:8]);
        frm_q.push_back(dport[7:0]);
        frm_q.push_back(ulen[15:8]);
        frm_q.push_back(ulen[7:0]);
        frm_q.push_back(8'h00);
        frm_q.push_back(8'h00);
        foreach (pay_q[i]) frm_q.push_back(pay_q[i]);
        for (int i = 0; i < 4; i++) frm_q.push_back(8'hA5);
        hdr_len = 3 + 14 + ihl * 4 + 8;
    endtask

    // mode 0: end strobe after the bytes, 1: end with the last byte sent, 2: no end strobe
    task automatic send_frame(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_byte  = frm_q[i];
            rx_valid = 1'b1;
            rx_end   = (mode == 1) && (i == n - 1);
            @(negedge clk);
            rx_valid = 1'b0;
            rx_end   = 1'b0;
        end
        if (mode == 0) begin
            @(negedge clk);
            rx_end = 1'b1;
            @(negedge clk);
            rx_end = 1'b0;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout sim_time=%0t limit=1ms", $time);
        $fatal(1, "timeout");
    end

    initial begin
        resetn   = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        rx_end   = 1'b0;
        nb_en    = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_valid", bus.payload_valid, 0);
        check("rst_payload", bus.payload, 0);
        check("rst_last", bus.payload_last, 0);
        check("rst_port", bus.payload_port, 0);
        check("rst_abort", bus.payload_abort, 0);
        check("rst_drop", bus.drop_pulse, 0);
        check("rst_count", bus.drop_count, 0);

        // Unicast, port 5006, four payload bytes
        pay_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build(1'b0, 5, 16'd5006, 16'd12, 1'b0, 1'b0);
        exp_beats(4, 2'd1, 1'b1);
        send_frame(frm_q.size(), 0);
        check("t1_count", bus.drop_count, exp_drops);

        // Broadcast: accepted by default instance, dropped by the strict one
        pay_q = {8'h11, 8'h22};
        build(1'b1, 5, 16'd5005, 16'd10, 1'b0, 1'b0);
        exp_beats(2, 2'd0, 1'b1);
        nb_en = 1'b1;
        send_frame(frm_q.size(), 0);
        nb_en = 1'b0;
        check("t2_count", bus.drop_count, exp_drops);
        check("t2_nb_count", nb.drop_count, 1);
        check("t2_nb_pulses", nb_drops, 1);
        check("t2_nb_beats", nb_beats, 0);

        // IPv4 options, good and corrupted checksum
        pay_q = {8'h01, 8'h02, 8'h03};
        build(1'b0, 6, 16'd5008, 16'd11, 1'b0, 1'b0);
        exp_beats(3, 2'd3, 1'b1);
        send_frame(frm_q.size(), 0);
        build(1'b0, 6, 16'd5008, 16'd11, 1'b0, 1'b1);
        exp_drop();
        send_frame(frm_q.size(), 0);
        check("t3_count", bus.drop_count, exp_drops);

        // Port range edges and fragment
        build(1'b0, 5, 16'd5009, 16'd11, 1'b0, 1'b0);
        exp_drop();
        send_frame(frm_q.size(), 0);
        build(1'b0, 5, 16'd5004, 16'd11, 1'b0, 1'b0);
        exp_drop();
        send_frame(frm_q.size(), 0);
        build(1'b0, 5, 16'd5005, 16'd11, 1'b1, 1'b0);
        exp_drop();
        send_frame(frm_q.size(), 0);
        check("t4_count", bus.drop_count, exp_drops);

        // Frame end inside the Ethernet header
        exp_drop();
        send_frame(10, 0);
        check("hdr_end_count", bus.drop_count, exp_drops);

        // Truncated payload -> abort
        pay_q = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        build(1'b0, 5, 16'd5007, 16'd12, 1'b0, 1'b0);
        exp_beats(2, 2'd2, 1'b0);
        sb.push_back({KAbort, 8'h00, 1'b0, 2'd0});
        send_frame(hdr_len + 2, 0);

        // Frame end together with the last payload byte
        exp_beats(4, 2'd2, 1'b1);
        send_frame(hdr_len + 4, 1);

        // Empty datagram
        pay_q.delete();
        build(1'b0, 5, 16'd5005, 16'd8, 1'b0, 1'b0);
        send_frame(frm_q.size(), 0);
        check("t6_count", bus.drop_count, exp_drops);

        // Reset mid-payload is silent and clears the counter
        pay_q = {8'hC1, 8'hC2, 8'hC3};
        build(1'b0, 5, 16'd5006, 16'd11, 1'b0, 1'b0);
        exp_beats(1, 2'd1, 1'b0);
        send_frame(hdr_len + 1, 2);
        resetn = 1'b0;
        exp_drops = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mid_count", bus.drop_count, exp_drops);
        pay_q = {8'h77};
        build(1'b0, 5, 16'd5005, 16'd9, 1'b0, 1'b0);
        exp_beats(1, 2'd0, 1'b1);
        send_frame(frm_q.size(), 0);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("final_count", bus.drop_count, exp_drops);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
